// File: rtl/sample_demux_packer_pkg.sv
// Shared definitions for the sample demux/packer capture stage:
// capture modes and word geometry helpers.
package sample_demux_packer_pkg;

  localparam logic MODE_SDR = 1'b0;
  localparam logic MODE_DDR = 1'b1;

  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 4;

  function automatic bit depth_ok(input int depth);
    return (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX);
  endfunction

  function automatic int units_per_word(input int depth);
    return 2 * depth;
  endfunction

endpackage

// File: rtl/sample_demux_packer_ddr_capture.sv
// Falling-edge sample alignment: delays the inverted-clock capture by one
// rising edge so it pairs with the following rising-edge sample.
module sample_demux_packer_ddr_capture #(
  parameter int CH = 16
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic [CH-1:0] i_indata,
  input  logic [CH-1:0] i_indata180,
  output logic [2*CH-1:0] o_pair
);

  // Must stay a distinct flop per channel so capture timing is preserved.
  (* equivalent_register_removal = "no" *) logic [CH-1:0] r_dly_indata180;

  always_ff @(posedge i_clock) begin
    if (i_reset) r_dly_indata180 <= '0;
    else         r_dly_indata180 <= i_indata180;
  end

  assign o_pair = {r_dly_indata180, i_indata};

endmodule

// File: rtl/sample_demux_packer.sv
// Packs SDR/DDR channel samples into 2*DEPTH-unit words with a valid/ready
// output register, zero-padded flush and sticky overrun detection.
module sample_demux_packer
  import sample_demux_packer_pkg::*;
#(
  parameter int CH    = 16,
  parameter int DEPTH = 1
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic                    i_ddr_mode,
  input  logic                    i_flush,
  input  logic                    i_clear_overrun,
  input  logic [CH-1:0]           i_indata,
  input  logic [CH-1:0]           i_indata180,
  output logic [2*CH*DEPTH-1:0]   o_outdata,
  output logic                    o_outvalid,
  input  logic                    i_outready,
  output logic                    o_overrun
);

  localparam int UNITS = units_per_word(DEPTH);
  localparam int FILLW = $clog2(UNITS);
  localparam int WORDW = CH * UNITS;

  generate
    if (!depth_ok(DEPTH)) begin : g_bad_depth
      $error("sample_demux_packer: DEPTH must be 1..4");
    end
  endgenerate

  logic [FILLW-1:0] r_fill;
  logic [WORDW-1:0] r_asm;
  logic [WORDW-1:0] r_outdata;
  logic             r_outvalid;
  logic             r_overrun;
  logic             r_mode;

  logic [2*CH-1:0]  w_pair;
  logic             w_step2;
  logic [FILLW:0]   w_fill_sum;
  logic             w_discard;
  logic             w_capture;
  logic             w_complete;
  logic             w_emit;
  logic             w_load;
  logic             w_drop;
  logic [WORDW-1:0] w_merged;
  logic [WORDW-1:0] w_emit_word;

  sample_demux_packer_ddr_capture #(.CH(CH)) u_capture (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_indata    (i_indata),
    .i_indata180 (i_indata180),
    .o_pair      (w_pair)
  );

  assign w_step2    = (i_ddr_mode == MODE_DDR);
  assign w_fill_sum = {1'b0, r_fill} + (w_step2 ? (FILLW+1)'(2) : (FILLW+1)'(1));

  // Flush outranks everything; a mode switch mid-word throws the partial word away.
  assign w_discard  = !i_flush && (i_ddr_mode != r_mode) && (r_fill != '0);
  assign w_capture  = !i_flush && !w_discard && i_enable;
  assign w_complete = w_capture && (w_fill_sum == (FILLW+1)'(UNITS));
  assign w_emit     = w_complete || (i_flush && (r_fill != '0));
  assign w_load     = w_emit && (!r_outvalid || i_outready);
  assign w_drop     = w_emit && r_outvalid && !i_outready;
  assign w_emit_word = i_flush ? r_asm : w_merged;

  always_comb begin
    w_merged = r_asm;
    for (int u = 0; u < UNITS; u++) begin
      if ((FILLW+1)'(u) == {1'b0, r_fill})
        w_merged[u*CH +: CH] = w_pair[CH-1:0];
      else if (w_step2 && ((FILLW+1)'(u) == ({1'b0, r_fill} + (FILLW+1)'(1))))
        w_merged[u*CH +: CH] = w_pair[2*CH-1:CH];
    end
  end

  // Assembly is zeroed whenever a word leaves so a later flush pads with zeros.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_fill     <= '0;
      r_asm      <= '0;
      r_outdata  <= '0;
      r_outvalid <= 1'b0;
      r_overrun  <= 1'b0;
      r_mode     <= MODE_SDR;
    end else begin
      r_mode <= i_ddr_mode;

      if (w_emit || w_discard) begin
        r_fill <= '0;
        r_asm  <= '0;
      end else if (w_capture) begin
        r_fill <= w_fill_sum[FILLW-1:0];
        r_asm  <= w_merged;
      end

      if (w_load) begin
        r_outdata  <= w_emit_word;
        r_outvalid <= 1'b1;
      end else if (r_outvalid && i_outready) begin
        r_outvalid <= 1'b0;
      end

      if (w_drop)               r_overrun <= 1'b1;
      else if (i_clear_overrun) r_overrun <= 1'b0;
    end
  end

  assign o_outdata  = r_outdata;
  assign o_outvalid = r_outvalid;
  assign o_overrun  = r_overrun;

endmodule
